// File: rtl/mdu_controller_pkg.sv
// -----------------------------------------------------------------------------
// mdu_controller_pkg
// Shared definitions for the multiply/divide unit: mdu_op encodings used by the
// decoder, the hazard unit and the MDU itself, default latencies, the MDU FSM
// state type and a helper that classifies the long (busy-producing) operations.
// -----------------------------------------------------------------------------
package mdu_controller_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6,
    MDU_MFHI  = 4'd7,
    MDU_MFLO  = 4'd8
  } mdu_op_t;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_t;

  // Operations that occupy the unit for several cycles.
  function automatic logic is_long_op(input mdu_op_t op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// -----------------------------------------------------------------------------
// mdu_arith
// Purely combinational arithmetic core of the MDU.
//   op       : mdu_op_t operation (only MULT/MULTU/DIV/DIVU produce a result)
//   a, b     : rs / rt operands
//   res      : {hi, lo}; for divides hi = remainder, lo = quotient
//   div_zero : divide operation with b == 0 (result must not be committed)
// -----------------------------------------------------------------------------
module mdu_arith
  import mdu_controller_pkg::*;
(
  input  mdu_op_t     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] res,
  output logic        div_zero
);

  logic signed [63:0] w_smul;
  logic        [63:0] w_umul;
  logic               w_b_zero;
  logic        [31:0] w_a_mag;
  logic        [31:0] w_b_mag;
  logic        [31:0] w_sdivisor;
  logic        [31:0] w_udivisor;
  logic        [31:0] w_q_mag;
  logic        [31:0] w_r_mag;
  logic        [31:0] w_sq;
  logic        [31:0] w_sr;
  logic        [31:0] w_uq;
  logic        [31:0] w_ur;

  assign w_smul = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign w_umul = {32'd0, a} * {32'd0, b};

  assign w_b_zero = (b == 32'd0);

  // Signed divide is done on magnitudes then sign-corrected. This gives
  // truncation toward zero, a remainder with the dividend's sign, and makes
  // -2^31 / -1 fall out as quotient 0x80000000, remainder 0 without overflow.
  assign w_a_mag = a[31] ? (~a + 32'd1) : a;
  assign w_b_mag = b[31] ? (~b + 32'd1) : b;

  // Divisor forced to 1 on zero so the dividers never see x / 0.
  assign w_sdivisor = w_b_zero ? 32'd1 : w_b_mag;
  assign w_udivisor = w_b_zero ? 32'd1 : b;

  assign w_q_mag = w_a_mag / w_sdivisor;
  assign w_r_mag = w_a_mag % w_sdivisor;
  assign w_sq    = (a[31] ^ b[31]) ? (~w_q_mag + 32'd1) : w_q_mag;
  assign w_sr    = a[31] ? (~w_r_mag + 32'd1) : w_r_mag;

  assign w_uq = a / w_udivisor;
  assign w_ur = a % w_udivisor;

  always_comb begin
    res      = 64'd0;
    div_zero = 1'b0;
    case (op)
      MDU_MULT:  res = w_smul;
      MDU_MULTU: res = w_umul;
      MDU_DIV: begin
        res      = {w_sr, w_sq};
        div_zero = w_b_zero;
      end
      MDU_DIVU: begin
        res      = {w_ur, w_uq};
        div_zero = w_b_zero;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_controller.sv
// -----------------------------------------------------------------------------
// mdu_controller
// E-stage sequencer for the multiply/divide unit and owner of HI/LO.
//   clk, reset   : rising-edge clock, asynchronous active-high reset
//   start        : E-stage MD instruction valid this cycle
//   mdu_op       : operation code (mdu_op_t encoding)
//   A, B         : forwarded rs / rt operands
//   md_D         : instruction in D is MD-class
//   busy         : long operation in progress (FSM is in RUN)
//   stall_req    : hold D while the unit is or is about to be occupied
//   HI, LO       : architectural HI/LO registers
//   md_out       : HI for MFHI, LO for MFLO, else 0 (combinational)
//
// Handshake: start is a single-cycle valid and busy is an inverted ready.
// A start is accepted only while busy=0; a start while busy=1 is dropped with
// no state change. Results of long ops are computed in the start cycle, held in
// a pending register, and committed to HI/LO on the edge that ends busy.
// -----------------------------------------------------------------------------
module mdu_controller
  import mdu_controller_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        md_D,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] md_out
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  mdu_state_t       r_state;
  mdu_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [63:0]      r_pend;
  logic [63:0]      w_pend_nxt;
  logic             r_pend_wr;
  logic             w_pend_wr_nxt;
  logic [31:0]      r_hi;
  logic [31:0]      w_hi_nxt;
  logic [31:0]      r_lo;
  logic [31:0]      w_lo_nxt;

  mdu_op_t          w_op;
  logic [63:0]      w_res;
  logic             w_div_zero;

  assign w_op = mdu_op_t'(mdu_op);

  mdu_arith u_arith (
    .op       (w_op),
    .a        (A),
    .b        (B),
    .res      (w_res),
    .div_zero (w_div_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_pend    <= 64'd0;
      r_pend_wr <= 1'b0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_pend    <= w_pend_nxt;
      r_pend_wr <= w_pend_wr_nxt;
      r_hi      <= w_hi_nxt;
      r_lo      <= w_lo_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_pend_nxt    = r_pend;
    w_pend_wr_nxt = r_pend_wr;
    w_hi_nxt      = r_hi;
    w_lo_nxt      = r_lo;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          case (w_op)
            MDU_MULT, MDU_MULTU: begin
              w_pend_nxt    = w_res;
              w_pend_wr_nxt = 1'b1;
              w_cnt_nxt     = CNT_W'(MULT_CYCLES);
              w_state_nxt   = ST_RUN;
            end
            MDU_DIV, MDU_DIVU: begin
              w_pend_nxt    = w_res;
              // Divide by zero still burns the full latency but commits nothing.
              w_pend_wr_nxt = ~w_div_zero;
              w_cnt_nxt     = CNT_W'(DIV_CYCLES);
              w_state_nxt   = ST_RUN;
            end
            MDU_MTHI: w_hi_nxt = A;
            MDU_MTLO: w_lo_nxt = A;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          if (r_pend_wr) begin
            w_hi_nxt = r_pend[63:32];
            w_lo_nxt = r_pend[31:0];
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign busy      = (r_state == ST_RUN);
  assign stall_req = md_D & (busy | (start & is_long_op(w_op)));
  assign HI        = r_hi;
  assign LO        = r_lo;

  always_comb begin
    md_out = 32'd0;
    case (w_op)
      MDU_MFHI: md_out = r_hi;
      MDU_MFLO: md_out = r_lo;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mdu_controller.sv
// -----------------------------------------------------------------------------
// tb_mdu_controller
// Directed testbench for mdu_controller. Inputs are driven on the falling edge
// and outputs are sampled on the falling edge, half a cycle from the active
// rising edge. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_mdu_controller;
  import mdu_controller_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  mdu_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        md_D;
  logic        busy;
  logic        stall_req;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] md_out;

  int n_cmp;
  int n_err;

  logic [31:0] exp_q[$];

  mdu_controller #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mdu_op    (mdu_op),
    .A         (A),
    .B         (B),
    .md_D      (md_D),
    .busy      (busy),
    .stall_req (stall_req),
    .HI        (HI),
    .LO        (LO),
    .md_out    (md_out)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  // Enter and leave at a falling edge. Drives one start cycle and returns the
  // stall_req sampled during that start cycle.
  task automatic issue(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic md,
                       output logic stall_at_start);
    start  = 1'b1;
    mdu_op = op;
    A      = a;
    B      = b;
    md_D   = md;
    #1;
    stall_at_start = stall_req;
    @(negedge clk);
    start  = 1'b0;
    mdu_op = MDU_NONE;
  endtask

  // Counts busy cycles until idle (bounded) and summarises stall_req.
  task automatic wait_idle(output int cycles, output logic all_stall,
                           output logic any_stall);
    cycles    = 0;
    all_stall = 1'b1;
    any_stall = 1'b0;
    while (busy === 1'b1 && cycles < 64) begin
      cycles++;
      if (stall_req !== 1'b1) all_stall = 1'b0;
      if (stall_req === 1'b1) any_stall = 1'b1;
      @(negedge clk);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    mdu_op = MDU_MFHI;
    md_D   = 1'b1;
    #1;
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    n_cmp++;
    if (HI !== 32'd0) begin n_err++; $display("FAIL reset_hi got=%h exp=00000000", HI); end
    n_cmp++;
    if (LO !== 32'd0) begin n_err++; $display("FAIL reset_lo got=%h exp=00000000", LO); end
    n_cmp++;
    if (stall_req !== 1'b0) begin n_err++; $display("FAIL reset_stall got=%0b exp=0", stall_req); end
    mdu_op = MDU_NONE;
    md_D   = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mult();
    logic s0, all_s, any_s;
    int   cyc;
    issue(MDU_MULT, 32'hFFFF_FFFD, 32'd5, 1'b1, s0);
    n_cmp++;
    if (s0 !== 1'b1) begin n_err++; $display("FAIL mult_stall_start got=%0b exp=1", s0); end
    wait_idle(cyc, all_s, any_s);
    n_cmp++;
    if (cyc != 5) begin n_err++; $display("FAIL mult_busy_cycles got=%0d exp=5", cyc); end
    n_cmp++;
    if (all_s !== 1'b1) begin n_err++; $display("FAIL mult_stall_busy got=%0b exp=1", all_s); end
    n_cmp++;
    if (HI !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mult_hi got=%h exp=ffffffff", HI); end
    n_cmp++;
    if (LO !== 32'hFFFF_FFF1) begin n_err++; $display("FAIL mult_lo got=%h exp=fffffff1", LO); end
    n_cmp++;
    if (stall_req !== 1'b0) begin n_err++; $display("FAIL mult_stall_idle got=%0b exp=0", stall_req); end
    md_D = 1'b0;
  endtask

  task automatic test_multu_mfhi();
    logic s0, all_s, any_s;
    int   cyc;
    issue(MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, s0);
    wait_idle(cyc, all_s, any_s);
    n_cmp++;
    if (cyc != 5) begin n_err++; $display("FAIL multu_busy_cycles got=%0d exp=5", cyc); end
    n_cmp++;
    if (any_s !== 1'b0) begin n_err++; $display("FAIL multu_stall_mdD0 got=%0b exp=0", any_s); end
    n_cmp++;
    if (HI !== 32'h0000_0001) begin n_err++; $display("FAIL multu_hi got=%h exp=00000001", HI); end
    n_cmp++;
    if (LO !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL multu_lo got=%h exp=fffffffe", LO); end
    start  = 1'b1;
    mdu_op = MDU_MFHI;
    #1;
    n_cmp++;
    if (md_out !== 32'h0000_0001) begin n_err++; $display("FAIL mfhi_out got=%h exp=00000001", md_out); end
    @(negedge clk);
    mdu_op = MDU_MFLO;
    #1;
    n_cmp++;
    if (md_out !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL mflo_out got=%h exp=fffffffe", md_out); end
    @(negedge clk);
    start  = 1'b0;
    mdu_op = MDU_MULT;
    #1;
    n_cmp++;
    if (md_out !== 32'd0) begin n_err++; $display("FAIL mdout_other got=%h exp=00000000", md_out); end
    n_cmp++;
    if (busy !== 1'b0 || HI !== 32'h1) begin
      n_err++; $display("FAIL mfx_no_state got busy=%0b hi=%h exp busy=0 hi=00000001", busy, HI);
    end
    mdu_op = MDU_NONE;
    @(negedge clk);
  endtask

  task automatic test_div();
    logic s0, all_s, any_s;
    int   cyc;
    issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, s0);
    wait_idle(cyc, all_s, any_s);
    n_cmp++;
    if (cyc != 10) begin n_err++; $display("FAIL div_busy_cycles got=%0d exp=10", cyc); end
    n_cmp++;
    if (LO !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div_lo got=%h exp=fffffffd", LO); end
    n_cmp++;
    if (HI !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL div_hi got=%h exp=ffffffff", HI); end
    issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, s0);
    wait_idle(cyc, all_s, any_s);
    n_cmp++;
    if (LO !== 32'h8000_0000) begin n_err++; $display("FAIL div_ovf_lo got=%h exp=80000000", LO); end
    n_cmp++;
    if (HI !== 32'h0000_0000) begin n_err++; $display("FAIL div_ovf_hi got=%h exp=00000000", HI); end
    // 7 / -2 : quotient -3, remainder +1 (dividend sign)
    issue(MDU_DIV, 32'd7, 32'hFFFF_FFFE, 1'b0, s0);
    wait_idle(cyc, all_s, any_s);
    n_cmp++;
    if (LO !== 32'hFFFF_FFFD || HI !== 32'h1) begin
      n_err++; $display("FAIL div_pos_neg got hi=%h lo=%h exp hi=00000001 lo=fffffffd", HI, LO);
    end
    // DIVU 0xFFFFFFF9 / 2 : 0x7FFFFFFC rem 1
    issue(MDU_DIVU, 32'hFFFF_FFF9, 32'd2, 1'b0, s0);
    wait_idle(cyc, all_s, any_s);
    n_cmp++;
    if (LO !== 32'h7FFF_FFFC || HI !== 32'h1) begin
      n_err++; $display("FAIL divu got hi=%h lo=%h exp hi=00000001 lo=7ffffffc", HI, LO);
    end
  endtask

  task automatic test_divu_zero();
    logic s0, all_s, any_s;
    int   cyc;
    issue(MDU_MTHI, 32'h11, 32'd0, 1'b0, s0);
    n_cmp++;
    if (HI !== 32'h11 || busy !== 1'b0) begin
      n_err++; $display("FAIL mthi got hi=%h busy=%0b exp hi=00000011 busy=0", HI, busy);
    end
    issue(MDU_MTLO, 32'h22, 32'd0, 1'b1, s0);
    n_cmp++;
    if (s0 !== 1'b0) begin n_err++; $display("FAIL mtlo_stall got=%0b exp=0", s0); end
    n_cmp++;
    if (LO !== 32'h22 || busy !== 1'b0) begin
      n_err++; $display("FAIL mtlo got lo=%h busy=%0b exp lo=00000022 busy=0", LO, busy);
    end
    md_D = 1'b0;
    issue(MDU_DIVU, 32'd7, 32'd0, 1'b0, s0);
    wait_idle(cyc, all_s, any_s);
    n_cmp++;
    if (cyc != 10) begin n_err++; $display("FAIL divz_busy_cycles got=%0d exp=10", cyc); end
    n_cmp++;
    if (HI !== 32'h11 || LO !== 32'h22) begin
      n_err++; $display("FAIL divz_unchanged got hi=%h lo=%h exp hi=00000011 lo=00000022", HI, LO);
    end
  endtask

  task automatic test_back_to_back_ignore();
    logic s0;
    int   cyc;
    issue(MDU_MULT, 32'd3, 32'd4, 1'b0, s0);
    cyc = 0;
    while (busy === 1'b1 && cyc < 64) begin
      cyc++;
      if (cyc == 2) begin
        start = 1'b1; mdu_op = MDU_DIVU; A = 32'd100; B = 32'd7;
      end else begin
        start = 1'b0; mdu_op = MDU_NONE;
      end
      @(negedge clk);
    end
    start  = 1'b0;
    mdu_op = MDU_NONE;
    n_cmp++;
    if (cyc != 5) begin n_err++; $display("FAIL ignore_busy_cycles got=%0d exp=5", cyc); end
    n_cmp++;
    if (HI !== 32'd0 || LO !== 32'd12) begin
      n_err++; $display("FAIL ignore_result got hi=%h lo=%h exp hi=00000000 lo=0000000c", HI, LO);
    end
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || LO !== 32'd12) begin
      n_err++; $display("FAIL ignore_settled got busy=%0b lo=%h exp busy=0 lo=0000000c", busy, LO);
    end
  endtask

  task automatic test_reset_mid_run();
    logic s0;
    issue(MDU_MTHI, 32'hAA, 32'd0, 1'b0, s0);
    issue(MDU_DIV, 32'd100, 32'd3, 1'b0, s0);
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL rst_pre_busy got=%0b exp=1", busy); end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      n_err++; $display("FAIL rst_mid_run got busy=%0b hi=%h lo=%h exp 0/00000000/00000000", busy, HI, LO);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    issue(MDU_MTLO, 32'h5, 32'd0, 1'b0, s0);
    n_cmp++;
    if (LO !== 32'h5 || busy !== 1'b0 || HI !== 32'd0) begin
      n_err++; $display("FAIL rst_then_mtlo got lo=%h busy=%0b hi=%h exp 00000005/0/00000000", LO, busy, HI);
    end
    for (int i = 0; i < 12; i++) @(negedge clk);
    exp_q.push_back(32'h5);
    n_cmp++;
    if (LO !== exp_q[0] || busy !== 1'b0) begin
      n_err++; $display("FAIL rst_abandoned got lo=%h busy=%0b exp lo=%h busy=0", LO, busy, exp_q[0]);
    end
    void'(exp_q.pop_front());
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    n_cmp  = 0;
    n_err  = 0;
    reset  = 1'b1;
    start  = 1'b0;
    mdu_op = MDU_NONE;
    A      = 32'd0;
    B      = 32'd0;
    md_D   = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b0;
    @(negedge clk);
    test_mult();
    test_multu_mfhi();
    test_div();
    test_divu_zero();
    test_back_to_back_ignore();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mdu_controller.md
Name: mdu_controller

Overview:
- Sequencer for the multiply/divide unit and the HI/LO architectural registers in the E stage of the pipelined MIPS CPU.
- Accepts one mult/multu/div/divu/mthi/mtlo per start pulse and models multi-cycle latency with a busy counter.
- Owns HI/LO and serves mfhi/mflo reads.
- Raises a stall request so the hazard unit holds MD-class instructions in D while the unit is occupied.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1).
- DIV_CYCLES, 10, busy cycles for div/divu (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  E-stage MD instruction valid this cycle.
- mdu_op  input  4  operation: NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO.
- A  input  32  rs operand, already forwarded.
- B  input  32  rt operand, already forwarded.
- md_D  input  1  instruction in D is MD-class (any mdu_op other than NONE).
- busy  output  1  long operation in progress.
- stall_req  output  1  hold D stage.
- HI  output  32  HI register.
- LO  output  32  LO register.
- md_out  output  32  HI for MFHI, LO for MFLO, else 0 (combinational on mdu_op).

Behaviour:
- Reset (async, immediate): state IDLE, busy=0, counter=0, HI=0, LO=0, pending result=0. stall_req depends only on md_D and start.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, counter loaded with N.
- IDLE, start=1, op MULT/MULTU/DIV/DIVU:
  - Compute the 64-bit result from A/B in that cycle and latch it into the pending register.
  - Load counter=N (MULT_CYCLES or DIV_CYCLES) and go to RUN.
  - busy is high for exactly N cycles after the start cycle.
- RUN: counter decrements every cycle. On the edge where counter==1:
  - write pending to HI/LO;
  - go to IDLE; busy falls on the same edge.
  - HI/LO show the new values in the first cycle with busy=0.
- IDLE, start=1, MTHI/MTLO: HI<=A or LO<=A at the next edge. No busy.
- start=1 while busy or in the start cycle of another op: ignored, no state change. The hazard unit guarantees this never occurs; verification still checks the ignore behaviour.
- MFHI/MFLO: md_out returns the current HI/LO. They never change state.
- stall_req = md_D & (busy | (start & op is MULT/MULTU/DIV/DIVU)).
  - mthi/mtlo in E does not stall D.
- Arithmetic rules:
  - MULT: signed 32x32 -> 64; HI=upper, LO=lower.
  - MULTU: unsigned 32x32 -> 64.
  - DIV: signed; quotient truncates toward zero; remainder takes the dividend's sign; LO=quotient, HI=remainder.
  - DIV -2^31 / -1: LO=0x80000000, HI=0.
  - DIVU: unsigned.
  - Divide by zero (DIV or DIVU): full DIV_CYCLES busy, then HI/LO unchanged. No pending write.
- Reset mid-RUN: operation abandoned, HI/LO=0, busy=0 immediately.
- No flush input. An exception/flush cannot cancel an MD op once it has started.

Decomposition:
- Shared define file: mdu_op encodings (NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MFHI=7, MFLO=8), plus the MULT_CYCLES/DIV_CYCLES defaults. The decoder and the hazard unit use the same constants.
- One sub-module, mdu_arith: purely combinational. Takes op, A, B; returns 64-bit {hi,lo} and div_zero.
- The controller holds the FSM, counter, pending and HI/LO registers.

Test Plan:
- MULT A=0xFFFFFFFD(-3), B=5 -> busy=1 for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- MULTU A=0xFFFFFFFF, B=2 -> after 5 busy cycles HI=0x00000001, LO=0xFFFFFFFE. MFHI then gives md_out=0x00000001.
- DIV A=-7, B=2 -> busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU A=7, B=0 with HI=0x11, LO=0x22 preloaded via MTHI/MTLO -> busy 10 cycles; HI=0x11, LO=0x22 unchanged.
- stall_req:
  - md_D=1 in the start cycle of MULT and during all busy cycles -> 1.
  - md_D=1 during an MTLO start -> 0.
  - md_D=0 while busy -> 0.
  - A start pulse with DIVU while busy -> ignored; HI/LO reflect only the first op.
- Assert reset on cycle 3 of a DIV -> busy, HI, LO all 0 immediately. Release reset, then MTLO A=0x5 -> LO=0x5 next cycle.
